// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron-bank blocks: arbiter state encoding and
// the default lateral-inhibition window length.
package neuron_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FIRE    = 2'd1,
    INHIBIT = 2'd2
  } arb_state_t;

  localparam int DEFAULT_INHIBIT_CYCLES = 4;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority picker: starting at ptr and scanning upward with
// wrap-around, selects the first asserted request. Purely combinational.
module rr_priority_picker #(
  parameter int N_NEURONS = 4,
  parameter int ID_W      = 2
) (
  input  logic [N_NEURONS-1:0] req,
  input  logic [ID_W-1:0]      ptr,
  output logic [N_NEURONS-1:0] grant,
  output logic [ID_W-1:0]      idx,
  output logic                 any_req
);

  int              cand;
  logic [ID_W-1:0] cand_idx;
  logic            found;

  // Walk the requests in priority order from ptr, keep the first hit.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path
    // leaves it unassigned, which would otherwise infer a latch.
    grant    = '0;
    idx      = '0;
    any_req  = |req;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N_NEURONS) cand = cand - N_NEURONS;
      cand_idx = ID_W'(cand);
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/spike_inhibit_arbiter.sv
// Lateral-inhibition scheduler: grants one spiking neuron round-robin, emits
// a one-cycle shared Pulse, then disables all other neurons for
// INHIBIT_CYCLES cycles. Requests arriving while busy are dropped and counted.
module spike_inhibit_arbiter
  import neuron_pkg::*;
#(
  parameter int N_NEURONS      = 4,
  parameter int INHIBIT_CYCLES = DEFAULT_INHIBIT_CYCLES,
  parameter int CNT_W          = 8,
  parameter int ID_W           = 2
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [N_NEURONS-1:0] Spike_req,
  output logic [N_NEURONS-1:0] Grant,
  output logic                 Pulse,
  output logic [ID_W-1:0]      Winner_id,
  output logic [N_NEURONS-1:0] Enable,
  output logic                 Inhibit_busy,
  output logic [CNT_W-1:0]     Drop_count
);

  if (N_NEURONS < 2) begin : g_chk_n
    $error("spike_inhibit_arbiter: N_NEURONS must be at least 2");
  end
  if (ID_W != $clog2(N_NEURONS)) begin : g_chk_id
    $error("spike_inhibit_arbiter: ID_W must equal clog2(N_NEURONS)");
  end
  if (INHIBIT_CYCLES < 0 || (INHIBIT_CYCLES >> CNT_W) != 0) begin : g_chk_cnt
    $error("spike_inhibit_arbiter: INHIBIT_CYCLES does not fit in CNT_W bits");
  end

  arb_state_t state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [N_NEURONS-1:0] grant_d, enable_d;
  logic                 pulse_d, busy_d;
  logic [ID_W-1:0]      winner_d;
  logic [CNT_W-1:0]     drop_d;

  logic [N_NEURONS-1:0] pick_grant;
  logic [ID_W-1:0]      pick_idx;
  logic                 any_req;

  rr_priority_picker #(
    .N_NEURONS (N_NEURONS),
    .ID_W      (ID_W)
  ) u_picker (
    .req     (Spike_req),
    .ptr     (ptr_q),
    .grant   (pick_grant),
    .idx     (pick_idx),
    .any_req (any_req)
  );

  // State register plus all registered outputs; Rst restores power-up values.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every register samples pre-edge values regardless of statement order.
      state_q      <= IDLE;
      cnt_q        <= '0;
      ptr_q        <= '0;
      Grant        <= '0;
      Pulse        <= 1'b0;
      Winner_id    <= '0;
      Enable       <= '1;
      Inhibit_busy <= 1'b0;
      Drop_count   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      Grant        <= grant_d;
      Pulse        <= pulse_d;
      Winner_id    <= winner_d;
      Enable       <= enable_d;
      Inhibit_busy <= busy_d;
      Drop_count   <= drop_d;
    end
  end

  // Next-state logic: IDLE -> FIRE on any request, FIRE lasts one cycle,
  // INHIBIT leaves when the window counter is on its final cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = FIRE;
      FIRE:    state_d = (INHIBIT_CYCLES == 0) ? IDLE : INHIBIT;
      INHIBIT: if (cnt_q == CNT_W'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values for the grant pulse, enables, window counter,
  // round-robin pointer and saturating drop counter.
  always_comb begin
    grant_d  = '0;
    pulse_d  = 1'b0;
    winner_d = Winner_id;
    enable_d = Enable;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    drop_d   = Drop_count;
    busy_d   = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        enable_d = '1;
        if (any_req) begin
          grant_d  = pick_grant;
          pulse_d  = 1'b1;
          winner_d = pick_idx;
          enable_d = pick_grant;
          ptr_d    = (pick_idx == ID_W'(N_NEURONS - 1)) ? '0 : pick_idx + ID_W'(1);
        end
      end
      FIRE: begin
        cnt_d = CNT_W'(INHIBIT_CYCLES);
        if (INHIBIT_CYCLES == 0) enable_d = '1;
      end
      INHIBIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) enable_d = '1;
      end
      default: enable_d = '1;
    endcase
    // While busy Enable holds only the winner bit, so ~Enable is the loser set;
    // the winner's own repeated request is neither queued nor counted.
    if (state_q != IDLE && |(Spike_req & ~Enable) && Drop_count != '1)
      drop_d = Drop_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_spike_inhibit_arbiter.sv
// Self-checking bench for spike_inhibit_arbiter. dut_a uses a 4-cycle
// inhibition window, dut_b a zero-length window. Both are compared against a
// window-countdown reference model built from the behavioural rules.
module tb_spike_inhibit_arbiter;

  logic       Clk;
  logic       rst_a, rst_b;
  logic [3:0] req_a, req_b;
  logic [3:0] grant_a, grant_b, enable_a, enable_b;
  logic       pulse_a, pulse_b, busy_a, busy_b;
  logic [1:0] winner_a, winner_b;
  logic [7:0] drop_a, drop_b;
  logic [19:0] obs_a, obs_b;

  int tests = 0;
  int fails = 0;

  spike_inhibit_arbiter #(.N_NEURONS(4), .INHIBIT_CYCLES(4), .CNT_W(8), .ID_W(2)) dut_a (
    .Clk(Clk), .Rst(rst_a), .Spike_req(req_a), .Grant(grant_a), .Pulse(pulse_a),
    .Winner_id(winner_a), .Enable(enable_a), .Inhibit_busy(busy_a), .Drop_count(drop_a)
  );

  spike_inhibit_arbiter #(.N_NEURONS(4), .INHIBIT_CYCLES(0), .CNT_W(8), .ID_W(2)) dut_b (
    .Clk(Clk), .Rst(rst_b), .Spike_req(req_b), .Grant(grant_b), .Pulse(pulse_b),
    .Winner_id(winner_b), .Enable(enable_b), .Inhibit_busy(busy_b), .Drop_count(drop_b)
  );

  assign obs_a = {grant_a, pulse_a, winner_a, enable_a, busy_a, drop_a};
  assign obs_b = {grant_b, pulse_b, winner_b, enable_b, busy_b, drop_b};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: 'left' counts remaining cycles in which losers are disabled.
  typedef struct {
    int         left;
    int         ptr;
    int         winner;
    int         drop;
    logic [3:0] grant;
    logic       pulse;
  } model_t;

  model_t ma, mb;

  function automatic model_t model_next(model_t m, logic [3:0] req, logic rst, int ic);
    model_t n;
    int     c;
    bit     found;
    logic [3:0] wmask;
    n       = m;
    n.grant = 4'b0;
    n.pulse = 1'b0;
    if (rst) begin
      n.left = 0; n.ptr = 0; n.winner = 0; n.drop = 0;
      return n;
    end
    if (m.left == 0) begin
      if (req != 4'b0) begin
        found = 0;
        for (int k = 0; k < 4; k++) begin
          c = (m.ptr + k) % 4;
          if (!found && req[2'(c)]) begin
            found    = 1;
            n.winner = c;
          end
        end
        n.grant = 4'(1 << n.winner);
        n.pulse = 1'b1;
        n.ptr   = (n.winner + 1) % 4;
        n.left  = 1 + ic;
      end
    end else begin
      wmask = 4'(1 << m.winner);
      if ((req & ~wmask) != 4'b0 && m.drop < 255) n.drop = m.drop + 1;
      n.left = m.left - 1;
    end
    return n;
  endfunction

  function automatic logic [19:0] exp_vec(model_t m);
    logic [3:0] en;
    logic       busy;
    busy = (m.left > 0);
    en   = busy ? 4'(1 << m.winner) : 4'b1111;
    return {m.grant, m.pulse, 2'(m.winner), en, busy, 8'(m.drop)};
  endfunction

  // Advance one clock: inputs already applied, model follows the same edge.
  task automatic step();
    @(posedge Clk);
    ma = model_next(ma, req_a, rst_a, 4);
    mb = model_next(mb, req_b, rst_b, 0);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1; rst_b = 1; req_a = 4'b0; req_b = 4'b0;
    step(); step();
    tests++;
    if (obs_a !== exp_vec(ma)) begin
      fails++; $display("FAIL reset_a_outputs: got %h expected %h", obs_a, exp_vec(ma));
    end
    tests++;
    if (enable_a !== 4'b1111 || grant_a !== 4'b0 || pulse_a !== 1'b0 || drop_a !== 8'd0) begin
      fails++;
      $display("FAIL reset_values: enable=%b grant=%b pulse=%b drop=%0d expected 1111/0000/0/0",
               enable_a, grant_a, pulse_a, drop_a);
    end
    tests++;
    if (obs_b !== exp_vec(mb)) begin
      fails++; $display("FAIL reset_b_outputs: got %h expected %h", obs_b, exp_vec(mb));
    end
    rst_a = 0; rst_b = 0;
  endtask

  task automatic test_single();
    int en_cycles = 0;
    req_a = 4'b0100;
    step();
    tests++;
    if (grant_a !== 4'b0100 || pulse_a !== 1'b1 || winner_a !== 2'd2) begin
      fails++;
      $display("FAIL single_grant: grant=%b pulse=%b winner=%0d expected 0100/1/2",
               grant_a, pulse_a, winner_a);
    end
    if (enable_a == 4'b0100) en_cycles++;
    req_a = 4'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      tests++;
      if (obs_a !== exp_vec(ma)) begin
        fails++; $display("FAIL single_cycle%0d: got %h expected %h", i, obs_a, exp_vec(ma));
      end
      if (enable_a == 4'b0100) en_cycles++;
    end
    tests++;
    if (en_cycles !== 5 || enable_a !== 4'b1111) begin
      fails++;
      $display("FAIL single_window: inhibited cycles=%0d final enable=%b expected 5/1111",
               en_cycles, enable_a);
    end
  endtask

  task automatic test_round_robin();
    int wins[$];
    int when[$];
    int exp_w[5] = '{0, 1, 2, 3, 0};
    rst_a = 1; step(); rst_a = 0;
    req_a = 4'b1111;
    for (int i = 0; i < 30; i++) begin
      step();
      tests++;
      if (obs_a !== exp_vec(ma)) begin
        fails++; $display("FAIL rr_cycle%0d: got %h expected %h", i, obs_a, exp_vec(ma));
      end
      if (pulse_a === 1'b1) begin
        wins.push_back(int'(winner_a));
        when.push_back(i);
      end
    end
    req_a = 4'b0;
    tests++;
    if (wins.size() < 5) begin
      fails++; $display("FAIL rr_grant_count: got %0d expected at least 5", wins.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        tests++;
        if (wins[k] !== exp_w[k]) begin
          fails++; $display("FAIL rr_order%0d: got winner %0d expected %0d", k, wins[k], exp_w[k]);
        end
      end
      for (int k = 1; k < 5; k++) begin
        tests++;
        if (when[k] - when[k-1] !== 6) begin
          fails++;
          $display("FAIL rr_spacing%0d: got %0d cycles expected 6", k, when[k] - when[k-1]);
        end
      end
    end
    // let the last window drain
    for (int i = 0; i < 6; i++) step();
  endtask

  task automatic test_drops();
    rst_a = 1; step(); rst_a = 0;
    req_a = 4'b0001; step();
    req_a = 4'b0010;
    for (int i = 0; i < 3; i++) step();
    tests++;
    if (drop_a !== 8'd3 || obs_a !== exp_vec(ma)) begin
      fails++; $display("FAIL drop_three: got drop=%0d expected 3 (obs %h model %h)",
                        drop_a, obs_a, exp_vec(ma));
    end
    req_a = 4'b1111;
    for (int i = 0; i < 400; i++) begin
      step();
      tests++;
      if (obs_a !== exp_vec(ma)) begin
        fails++; $display("FAIL drop_cycle%0d: got %h expected %h", i, obs_a, exp_vec(ma));
      end
    end
    tests++;
    if (drop_a !== 8'd255) begin
      fails++; $display("FAIL drop_saturate: got %0d expected 255", drop_a);
    end
    req_a = 4'b0;
  endtask

  task automatic test_reset_mid();
    rst_a = 1; step(); rst_a = 0;
    req_a = 4'b0001; step();
    req_a = 4'b0;
    step(); step(); step();
    rst_a = 1; step(); rst_a = 0;
    tests++;
    if (enable_a !== 4'b1111 || busy_a !== 1'b0 || obs_a !== exp_vec(ma)) begin
      fails++; $display("FAIL midreset_state: enable=%b busy=%b expected 1111/0", enable_a, busy_a);
    end
    req_a = 4'b1010; step(); req_a = 4'b0;
    tests++;
    if (winner_a !== 2'd1 || grant_a !== 4'b0010 || pulse_a !== 1'b1) begin
      fails++; $display("FAIL midreset_priority: winner=%0d grant=%b expected 1/0010",
                        winner_a, grant_a);
    end
    for (int i = 0; i < 6; i++) step();
  endtask

  task automatic test_inhibit_zero();
    int pulses = 0;
    rst_b = 1; step(); rst_b = 0;
    req_b = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      step();
      tests++;
      if (obs_b !== exp_vec(mb)) begin
        fails++; $display("FAIL zero_cycle%0d: got %h expected %h", i, obs_b, exp_vec(mb));
      end
      if (pulse_b === 1'b1) pulses++;
      tests++;
      if (enable_b !== (pulse_b ? 4'b0001 : 4'b1111)) begin
        fails++; $display("FAIL zero_enable%0d: enable=%b pulse=%b", i, enable_b, pulse_b);
      end
    end
    tests++;
    if (pulses !== 5) begin
      fails++; $display("FAIL zero_pulse_rate: got %0d pulses in 10 cycles expected 5", pulses);
    end
    req_b = 4'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      req_a = 4'($urandom_range(0, 15));
      req_b = 4'($urandom_range(0, 15));
      rst_a = ($urandom_range(0, 49) == 0);
      rst_b = ($urandom_range(0, 49) == 0);
      step();
      tests++;
      if (obs_a !== exp_vec(ma)) begin
        fails++; $display("FAIL random_a%0d: got %h expected %h", i, obs_a, exp_vec(ma));
      end
      tests++;
      if (obs_b !== exp_vec(mb)) begin
        fails++; $display("FAIL random_b%0d: got %h expected %h", i, obs_b, exp_vec(mb));
      end
    end
    rst_a = 0; rst_b = 0; req_a = 4'b0; req_b = 4'b0;
  endtask

  initial begin
    ma = '{left: 0, ptr: 0, winner: 0, drop: 0, grant: 4'b0, pulse: 1'b0};
    mb = ma;
    test_reset();
    test_single();
    test_round_robin();
    test_drops();
    test_reset_mid();
    test_inhibit_zero();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
